// File: rtl/alu_32b.sv
// 32-bit MIPS-style ALU: add/sub, mult/div into HI/LO, isqrt, logic ops, slt.
// Result and flags registered one cycle after sampling; no handshake, accepts one op every cycle.
module alu_32b (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [5:0]  opcode,
   output logic [31:0] c,
   output logic [2:0]  zon,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [5:0] OP_ADD   = 6'h01;
   localparam logic [5:0] OP_ADDI  = 6'h02;
   localparam logic [5:0] OP_ADDU  = 6'h03;
   localparam logic [5:0] OP_ADDIU = 6'h04;
   localparam logic [5:0] OP_SUB   = 6'h05;
   localparam logic [5:0] OP_SUBU  = 6'h06;
   localparam logic [5:0] OP_MULT  = 6'h07;
   localparam logic [5:0] OP_MULTU = 6'h08;
   localparam logic [5:0] OP_DIV   = 6'h09;
   localparam logic [5:0] OP_DIVU  = 6'h0A;
   localparam logic [5:0] OP_SQRT  = 6'h0B;
   localparam logic [5:0] OP_AND   = 6'h0C;
   localparam logic [5:0] OP_ANDI  = 6'h0D;
   localparam logic [5:0] OP_OR    = 6'h0E;
   localparam logic [5:0] OP_ORI   = 6'h0F;
   localparam logic [5:0] OP_NOR   = 6'h10;
   localparam logic [5:0] OP_XOR   = 6'h11;
   localparam logic [5:0] OP_XNOR  = 6'h12;
   localparam logic [5:0] OP_SLT   = 6'h13;
   localparam logic [5:0] OP_SLTI  = 6'h14;

   // Restoring divider; returns {remainder, quotient}. d==0 yields q=all ones, r=n.
   function automatic logic [63:0] udiv32(input logic [31:0] n, input logic [31:0] d);
      logic [32:0] rem;
      logic [31:0] quo;
      rem = 33'd0;
      quo = 32'd0;
      for (int i = 31; i >= 0; i--) begin
         rem = {rem[31:0], n[i]};
         if (rem >= {1'b0, d}) begin
            rem    = rem - {1'b0, d};
            quo[i] = 1'b1;
         end
      end
      return {rem[31:0], quo};
   endfunction

   // Digit-by-digit integer square root, two radicand bits per step.
   function automatic logic [31:0] isqrt32(input logic [31:0] n);
      logic [31:0] op;
      logic [31:0] res;
      logic [31:0] one;
      op  = n;
      res = 32'd0;
      one = 32'h4000_0000;
      for (int i = 0; i < 16; i++) begin
         if (op >= res + one) begin
            op  = op - (res + one);
            res = (res >> 1) + one;
         end else begin
            res = res >> 1;
         end
         one = one >> 2;
      end
      return res;
   endfunction

   logic [31:0] c_q, c_d;
   logic [2:0]  zon_q, zon_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        hilo_we;
   logic        ovf;

   logic [31:0] imm_sext, imm_zext;
   assign imm_sext = {{16{b[15]}}, b[15:0]};
   assign imm_zext = {16'd0, b[15:0]};

   // Adder path shared by add/addi/addu/addiu; subtract is separate to get its overflow right
   logic [31:0] add_b;
   logic [31:0] sum;
   logic [31:0] diff;
   logic        add_ovf;
   logic        sub_ovf;

   always_comb begin
      add_b = b;
      if (opcode == OP_ADDI || opcode == OP_ADDIU) begin
         add_b = imm_sext;
      end
      sum     = a + add_b;
      diff    = a - b;
      add_ovf = (a[31] == add_b[31]) && (sum[31] != a[31]);
      sub_ovf = (a[31] != b[31]) && (diff[31] != a[31]);
   end

   logic [63:0] prod_s;
   logic [63:0] prod_u;

   always_comb begin
      prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      prod_u = {32'd0, a} * {32'd0, b};
   end

   logic [31:0] a_abs, b_abs;
   logic [63:0] udiv_res;
   logic [63:0] sdiv_mag;
   logic [31:0] sdiv_q, sdiv_r;
   logic        b_zero;

   always_comb begin
      b_zero   = (b == 32'd0);
      a_abs    = a[31] ? (~a + 32'd1) : a;
      b_abs    = b[31] ? (~b + 32'd1) : b;
      udiv_res = udiv32(a, b);
      sdiv_mag = udiv32(a_abs, b_abs);
      sdiv_q   = (a[31] ^ b[31]) ? (~sdiv_mag[31:0] + 32'd1) : sdiv_mag[31:0];
      sdiv_r   = a[31] ? (~sdiv_mag[63:32] + 32'd1) : sdiv_mag[63:32];
      // Sign fix-ups would corrupt the divide-by-zero result, so force it explicitly
      if (b_zero) begin
         sdiv_q = 32'hFFFF_FFFF;
         sdiv_r = a;
      end
   end

   logic [31:0] sqrt_res;
   assign sqrt_res = isqrt32(a);

   logic        slt_res;
   logic        slti_res;
   assign slt_res  = $signed(a) < $signed(b);
   assign slti_res = $signed(a) < $signed(imm_sext);

   always_comb begin
      c_d     = 32'd0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      hilo_we = 1'b0;
      ovf     = 1'b0;
      case (opcode)
         OP_ADD, OP_ADDI: begin
            c_d = sum;
            ovf = add_ovf;
         end
         OP_ADDU, OP_ADDIU: c_d = sum;
         OP_SUB: begin
            c_d = diff;
            ovf = sub_ovf;
         end
         OP_SUBU: c_d = diff;
         OP_MULT: begin
            hi_d    = prod_s[63:32];
            lo_d    = prod_s[31:0];
            c_d     = prod_s[31:0];
            hilo_we = 1'b1;
         end
         OP_MULTU: begin
            hi_d    = prod_u[63:32];
            lo_d    = prod_u[31:0];
            c_d     = prod_u[31:0];
            hilo_we = 1'b1;
         end
         OP_DIV: begin
            hi_d    = sdiv_r;
            lo_d    = sdiv_q;
            c_d     = sdiv_q;
            hilo_we = 1'b1;
         end
         OP_DIVU: begin
            hi_d    = udiv_res[63:32];
            lo_d    = udiv_res[31:0];
            c_d     = udiv_res[31:0];
            hilo_we = 1'b1;
         end
         OP_SQRT: c_d = sqrt_res;
         OP_AND:  c_d = a & b;
         OP_ANDI: c_d = a & imm_zext;
         OP_OR:   c_d = a | b;
         OP_ORI:  c_d = a | imm_zext;
         OP_NOR:  c_d = ~(a | b);
         OP_XOR:  c_d = a ^ b;
         OP_XNOR: c_d = ~(a ^ b);
         OP_SLT:  c_d = {31'd0, slt_res};
         OP_SLTI: c_d = {31'd0, slti_res};
         default: c_d = 32'd0;
      endcase
      zon_d = {(c_d == 32'd0), ovf, c_d[31]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_q   <= 32'd0;
         zon_q <= 3'd0;
         hi_q  <= 32'd0;
         lo_q  <= 32'd0;
      end else begin
         c_q   <= c_d;
         zon_q <= zon_d;
         if (hilo_we) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
         end
      end
   end

   assign c   = c_q;
   assign zon = zon_q;
   assign hi  = hi_q;
   assign lo  = lo_q;

endmodule

// File: tb/tb_alu_32b.sv
// Directed-vector bench for alu_32b with hand-computed expectations.
module tb_alu_32b;

   logic        clk;
   logic        rst;
   logic [31:0] a;
   logic [31:0] b;
   logic [5:0]  opcode;
   logic [31:0] c;
   logic [2:0]  zon;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks = 0;
   int n_fail   = 0;

   alu_32b dut (
      .clk    (clk),
      .rst    (rst),
      .a      (a),
      .b      (b),
      .opcode (opcode),
      .c      (c),
      .zon    (zon),
      .hi     (hi),
      .lo     (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Drive on the falling edge, sample just after the next rising edge
   task automatic run_op(input logic [5:0] op, input logic [31:0] av, input logic [31:0] bv);
      @(negedge clk);
      opcode = op;
      a      = av;
      b      = bv;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_c_zon(input string tag, input logic [31:0] ec, input logic [2:0] ez);
      check({tag, ".c"}, c, ec);
      check({tag, ".zon"}, {29'd0, zon}, {29'd0, ez});
   endtask

   initial begin
      rst    = 1'b1;
      a      = 32'd0;
      b      = 32'd0;
      opcode = 6'h00;
      #12;
      check("rst.c", c, 32'd0);
      check("rst.zon", {29'd0, zon}, 32'd0);
      check("rst.hi", hi, 32'd0);
      check("rst.lo", lo, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op(6'h01, 32'h4040_4040, 32'hDDDD_DDDD); chk_c_zon("add", 32'h1E1E_1E1D, 3'b000);
      run_op(6'h01, 32'h4040_4040, 32'h5DDD_DDDD); chk_c_zon("add_ovf", 32'h9E1E_1E1D, 3'b011);
      run_op(6'h02, 32'h7FFF_FFFF, 32'h0000_FFFF); chk_c_zon("addi", 32'h7FFF_FFFE, 3'b000);
      run_op(6'h03, 32'h7FFF_FFFF, 32'h0000_0001); chk_c_zon("addu", 32'h8000_0000, 3'b001);
      run_op(6'h04, 32'h0000_0001, 32'h0000_8000); chk_c_zon("addiu", 32'hFFFF_8001, 3'b001);
      run_op(6'h05, 32'h5DDD_DDDD, 32'h5DDD_DDDD); chk_c_zon("sub_zero", 32'h0, 3'b100);
      run_op(6'h05, 32'h8000_0000, 32'h0000_0001); chk_c_zon("sub_ovf", 32'h7FFF_FFFF, 3'b010);
      run_op(6'h06, 32'h8000_0000, 32'h0000_0001); chk_c_zon("subu", 32'h7FFF_FFFF, 3'b000);

      run_op(6'h07, 32'hFFFF_FFFF, 32'h0000_0001); chk_c_zon("mult", 32'hFFFF_FFFF, 3'b001);
      check("mult.hi", hi, 32'hFFFF_FFFF);
      check("mult.lo", lo, 32'hFFFF_FFFF);
      run_op(6'h0C, 32'hF0F0_F0F0, 32'h0FFF_0000); chk_c_zon("and", 32'h00F0_0000, 3'b000);
      check("and.hi_hold", hi, 32'hFFFF_FFFF);
      check("and.lo_hold", lo, 32'hFFFF_FFFF);
      run_op(6'h08, 32'hFFFF_FFFF, 32'hFFFF_FFFF); chk_c_zon("multu", 32'h0000_0001, 3'b000);
      check("multu.hi", hi, 32'hFFFF_FFFE);
      check("multu.lo", lo, 32'h0000_0001);

      run_op(6'h09, 32'hFFFF_FFE1, 32'h0000_0011); chk_c_zon("div", 32'hFFFF_FFFF, 3'b001);
      check("div.hi", hi, 32'hFFFF_FFF2);
      check("div.lo", lo, 32'hFFFF_FFFF);
      run_op(6'h09, 32'h0000_0064, 32'h0000_0007); chk_c_zon("div_pos", 32'h0000_000E, 3'b000);
      check("div_pos.hi", hi, 32'h0000_0002);
      run_op(6'h09, 32'h8000_0000, 32'hFFFF_FFFF); chk_c_zon("div_min", 32'h8000_0000, 3'b001);
      check("div_min.hi", hi, 32'h0);
      check("div_min.lo", lo, 32'h8000_0000);
      run_op(6'h09, 32'hFFFF_FFFB, 32'h0); chk_c_zon("div_by0", 32'hFFFF_FFFF, 3'b001);
      check("div_by0.hi", hi, 32'hFFFF_FFFB);
      check("div_by0.lo", lo, 32'hFFFF_FFFF);
      run_op(6'h0A, 32'h0000_000D, 32'h0); chk_c_zon("divu_by0", 32'hFFFF_FFFF, 3'b001);
      check("divu_by0.hi", hi, 32'h0000_000D);
      check("divu_by0.lo", lo, 32'hFFFF_FFFF);
      run_op(6'h0A, 32'hFFFF_FFFF, 32'h0000_0010); chk_c_zon("divu", 32'h0FFF_FFFF, 3'b000);
      check("divu.hi", hi, 32'h0000_000F);

      run_op(6'h0B, 32'h0000_007A, 32'h1234_5678); chk_c_zon("sqrt", 32'h0000_000B, 3'b000);
      run_op(6'h0B, 32'hFFFF_FFFF, 32'h0);         chk_c_zon("sqrt_max", 32'h0000_FFFF, 3'b000);
      run_op(6'h0B, 32'h0, 32'h0);                 chk_c_zon("sqrt_zero", 32'h0, 3'b100);
      check("sqrt.hi_hold", hi, 32'h0000_000F);

      run_op(6'h0D, 32'hFFFF_FFFF, 32'hFFFF_1234); chk_c_zon("andi", 32'h0000_1234, 3'b000);
      run_op(6'h0E, 32'h1200_0034, 32'h0000_5600); chk_c_zon("or", 32'h1200_5634, 3'b000);
      run_op(6'h0F, 32'h0, 32'hFFFF_8000);         chk_c_zon("ori", 32'h0000_8000, 3'b000);
      run_op(6'h10, 32'h0, 32'h0);                 chk_c_zon("nor", 32'hFFFF_FFFF, 3'b001);
      run_op(6'h11, 32'hF0F0_F0F0, 32'hFF00_FF00); chk_c_zon("xor", 32'h0FF0_0FF0, 3'b000);
      run_op(6'h12, 32'hF0F0_F0F0, 32'hFF00_FF00); chk_c_zon("xnor", 32'hF00F_F00F, 3'b001);
      run_op(6'h13, 32'hDDDD_DDDC, 32'hDDDD_DDDD); chk_c_zon("slt_t", 32'h1, 3'b000);
      run_op(6'h13, 32'h4040_4040, 32'hDDDD_DDDD); chk_c_zon("slt_f", 32'h0, 3'b100);
      run_op(6'h14, 32'hFFFF_FFFE, 32'h0000_FFFF); chk_c_zon("slti", 32'h1, 3'b000);

      run_op(6'h00, 32'h1234_5678, 32'h1); chk_c_zon("undef00", 32'h0, 3'b100);
      run_op(6'h3F, 32'hFFFF_FFFF, 32'h1); chk_c_zon("undef3f", 32'h0, 3'b100);
      check("undef.hi_hold", hi, 32'h0000_000F);
      check("undef.lo_hold", lo, 32'h0FFF_FFFF);

      // Asynchronous clear away from any rising edge
      run_op(6'h07, 32'h0001_0000, 32'h0001_0000);
      check("pre_rst.hi", hi, 32'h0000_0001);
      #2;
      rst = 1'b1;
      #1;
      check("arst.c", c, 32'd0);
      check("arst.zon", {29'd0, zon}, 32'd0);
      check("arst.hi", hi, 32'd0);
      check("arst.lo", lo, 32'd0);
      run_op(6'h01, 32'h1, 32'h1);
      check("rst_hold.c", c, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op(6'h01, 32'h0000_0002, 32'h0000_0003); chk_c_zon("post_rst", 32'h0000_0005, 3'b000);
      check("post_rst.hi", hi, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
